// File: rtl/seq_edge_count_cfg.sv
// Edge-event counter for a monitored bus: rising/falling/any edges,
// per-cycle or per-bit accumulation, wrap or saturate, overflow and threshold hit.
module seq_edge_count_cfg #(
   parameter int NBITS  = 8,
   parameter int CWIDTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [1:0]        mode,
   input  logic              sum,
   input  logic              sat,
   input  logic [CWIDTH-1:0] thresh,
   input  logic [NBITS-1:0]  in_,
   output logic [NBITS-1:0]  edges,
   output logic [CWIDTH-1:0] count,
   output logic              overflow,
   output logic              hit
);

   localparam int PW = $clog2(NBITS + 1);
   // Sum is wide enough for count plus a full popcount without truncation.
   localparam int SW = ((CWIDTH > PW) ? CWIDTH : PW) + 1;
   localparam logic [SW-1:0] CMAX = SW'({CWIDTH{1'b1}});

   logic [NBITS-1:0] prev_in;
   logic [NBITS-1:0] rising;
   logic [NBITS-1:0] falling;
   logic [PW-1:0]    pop;
   logic [SW-1:0]    inc;
   logic [SW-1:0]    s;
   logic             ovf;

   assign rising  = in_ & ~prev_in;
   assign falling = ~in_ & prev_in;

   always_comb begin
      edges = rising | falling;
      case (mode)
         2'b00:   edges = rising;
         2'b01:   edges = falling;
         default: edges = rising | falling;
      endcase
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < NBITS; i++) begin
         pop = pop + PW'(edges[i]);
      end
   end

   assign inc = sum ? SW'(pop) : SW'(|edges);
   assign s   = SW'(count) + inc;
   assign ovf = s > CMAX;
   assign hit = count >= thresh;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_in  <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         prev_in <= in_;
         if (clear) begin
            count    <= '0;
            overflow <= 1'b0;
         end else if (ovf) begin
            count    <= sat ? {CWIDTH{1'b1}} : s[CWIDTH-1:0];
            overflow <= 1'b1;
         end else begin
            count <= s[CWIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_seq_edge_count_cfg.sv
// Directed bench for seq_edge_count_cfg with a per-cycle reference model
// and hand-computed literal checkpoints.
module tb_seq_edge_count_cfg;

   localparam int NB = 8;
   localparam int CW = 8;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          clear = 1'b0;
   logic [1:0]    mode = 2'b10;
   logic          sum = 1'b0;
   logic          sat = 1'b0;
   logic [CW-1:0] thresh = '0;
   logic [NB-1:0] in_ = '0;
   logic [NB-1:0] edges;
   logic [CW-1:0] count;
   logic          overflow;
   logic          hit;

   int vectors = 0;
   int miscompares = 0;

   int            m_cnt = 0;
   bit            m_ov = 1'b0;
   logic [NB-1:0] m_prev = '0;

   seq_edge_count_cfg #(.NBITS(NB), .CWIDTH(CW)) dut (
      .clk(clk), .reset(reset), .clear(clear), .mode(mode),
      .sum(sum), .sat(sat), .thresh(thresh), .in_(in_),
      .edges(edges), .count(count), .overflow(overflow), .hit(hit)
   );

   always #5 clk = ~clk;

   function automatic logic [NB-1:0] m_edges(
      input logic [NB-1:0] a, input logic [NB-1:0] p, input logic [1:0] m);
      logic [NB-1:0] e;
      for (int i = 0; i < NB; i++) begin
         bit up, dn;
         up = (a[i] == 1'b1) && (p[i] == 1'b0);
         dn = (a[i] == 1'b0) && (p[i] == 1'b1);
         if (m == 2'b00)      e[i] = up;
         else if (m == 2'b01) e[i] = dn;
         else                 e[i] = up || dn;
      end
      return e;
   endfunction

   // Reference model: integer arithmetic on the counting rules.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cnt  = 0;
         m_ov   = 1'b0;
         m_prev = '0;
      end else begin
         logic [NB-1:0] e;
         int n;
         e = m_edges(in_, m_prev, mode);
         if (clear) begin
            m_cnt = 0;
            m_ov  = 1'b0;
         end else begin
            n = m_cnt + (sum ? $countones(e) : ((e != 0) ? 1 : 0));
            if (n > MAXC) begin
               m_ov  = 1'b1;
               m_cnt = sat ? MAXC : (n % (MAXC + 1));
            end else begin
               m_cnt = n;
            end
         end
         m_prev = in_;
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("m_edges", int'(edges), int'(m_edges(in_, m_prev, mode)));
      chk("m_count", int'(count), m_cnt);
      chk("m_overflow", int'(overflow), int'(m_ov));
      chk("m_hit", int'(hit), (m_cnt >= int'(thresh)) ? 1 : 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply a vector, check pre-edge count and edges, then clock it in.
   task automatic vec(input logic [NB-1:0] v, input logic [NB-1:0] e,
                      input int c);
      in_ = v;
      #1;
      chk("edges", int'(edges), int'(e));
      chk("count", int'(count), c);
      tick();
   endtask

   task automatic vc(input logic [NB-1:0] v, input int c);
      in_ = v;
      #1;
      chk("count", int'(count), c);
      tick();
   endtask

   task automatic do_clear(input logic [NB-1:0] v);
      clear = 1'b1;
      in_ = v;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_count", int'(count), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_hit_t0", int'(hit), 1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // 1: any-change, per-cycle counting
      mode = 2'b10; sum = 1'b0; sat = 1'b0;
      vec(8'h00, 8'h00, 0);
      vec(8'h01, 8'h01, 0);
      vec(8'h00, 8'h01, 1);
      vec(8'h01, 8'h01, 2);
      vec(8'h00, 8'h01, 3);
      vec(8'h00, 8'h00, 4);

      // 2: popcount of rising, then falling
      do_clear(8'h00);
      mode = 2'b00; sum = 1'b1;
      vc(8'h00, 0);
      vec(8'hAA, 8'hAA, 0);
      vec(8'h00, 8'h00, 4);
      vec(8'hFF, 8'hFF, 4);
      vc(8'hFF, 12);
      do_clear(8'h00);
      mode = 2'b01;
      vc(8'h00, 0);
      vc(8'hAA, 0);
      vec(8'h00, 8'hAA, 0);
      vc(8'hFF, 4);
      vec(8'h00, 8'hFF, 4);
      vc(8'h00, 12);

      // 3: saturate, then wrap
      do_clear(8'h00);
      mode = 2'b10; sum = 1'b1; sat = 1'b1;
      for (int i = 0; i < 32; i++) begin
         in_ = (i % 2 == 0) ? 8'hFF : 8'h00;
         tick();
      end
      chk("sat_count", int'(count), 255);
      chk("sat_ovf", int'(overflow), 1);
      vc(8'hFF, 255);
      chk("sat_hold", int'(count), 255);
      chk("sat_hold_ovf", int'(overflow), 1);

      do_clear(8'h00);
      sat = 1'b0;
      for (int i = 0; i < 32; i++) begin
         in_ = (i % 2 == 0) ? 8'hFF : 8'h00;
         tick();
      end
      chk("wrap_count", int'(count), 0);
      chk("wrap_ovf", int'(overflow), 1);
      vc(8'hFF, 0);
      chk("wrap_next", int'(count), 8);
      chk("wrap_next_ovf", int'(overflow), 1);

      // 4: clear with a simultaneous edge
      mode = 2'b00;
      vc(8'h00, 8);
      vc(8'h0F, 8);
      vc(8'h00, 12);
      chk("pre_clr_ovf", int'(overflow), 1);
      clear = 1'b1;
      vec(8'hFF, 8'hFF, 12);
      clear = 1'b0;
      chk("clr_count", int'(count), 0);
      chk("clr_ovf", int'(overflow), 0);
      vc(8'hFF, 0);
      chk("clr_hold", int'(count), 0);

      // 5: asynchronous reset between edges
      vc(8'h00, 0);
      vc(8'hFF, 0);
      vc(8'h00, 8);
      vc(8'h0F, 8);
      chk("pre_rst", int'(count), 12);
      #2 reset = 1'b1;
      #1;
      chk("arst_count", int'(count), 0);
      chk("arst_ovf", int'(overflow), 0);
      in_ = 8'h01;
      mode = 2'b00;
      #1 reset = 1'b0;
      vec(8'h01, 8'h01, 0);
      chk("post_rst", int'(count), 1);

      // 6: threshold
      do_clear(8'h01);
      thresh = 8'd3; mode = 2'b10; sum = 1'b0;
      #1;
      chk("hit_0", int'(hit), 0);
      vc(8'h00, 0);
      chk("hit_1", int'(hit), 0);
      vc(8'h01, 1);
      chk("hit_2", int'(hit), 0);
      vc(8'h00, 2);
      chk("hit_3", int'(hit), 1);
      thresh = 8'd0;
      #1;
      chk("hit_t0", int'(hit), 1);
      thresh = 8'd200;
      #1;
      chk("hit_t200", int'(hit), 0);
      thresh = 8'd0;
      reset = 1'b1;
      #1;
      chk("hit_rst", int'(hit), 1);
      chk("count_rst", int'(count), 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
